res_to_bcd: RTL and testbench
=============================

# res_to_bcd

Sequential sign-magnitude binary-to-BCD converter placed directly downstream of the multiplier stage. Accepts the multiplier's 17-bit result word: bit 16 is the sign, bits 15:0 are the unsigned magnitude. Converts the magnitude to five packed BCD digits with a shift-add-3 (double-dabble) engine, one bit per clock, and presents the digits, the sign, and an optional seven-segment drive to the board display logic.

## Interface
- N, 16, magnitude width in bits; the sign sits at bit N of Res.
- DIGITS, 5, BCD digit count. Must satisfy 10^DIGITS > 2^N - 1.
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  conversion request; sampled only in IDLE or DONE.
- Res  input  N+1  sign-magnitude operand; Res[N] is the sign, Res[N-1:0] is the magnitude.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when BCD and Sign are updated.
- Sign  output  1  registered sign of the last converted operand.
- BCD  output  4*DIGITS  packed digits; BCD[3:0] is the units digit.
- Hex  output  7*(DIGITS+1)  active-low seven-segment patterns, digits 0..DIGITS-1, then the sign display.

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- Reset values: Busy=0, Done=0, Sign=0, BCD=0, Hex=all ones (blank); the internal shift register and bit counter are cleared.
- Start accepted in IDLE or DONE:
  - Capture Res[N-1:0] into the binary shift register.
  - Clear the BCD working register.
  - Latch the pending sign as Res[N] AND (magnitude != 0), so negative zero converts to +0.
  - Load the counter with N and go to SHIFT.
- SHIFT, each cycle:
  - Any working digit >= 5 gets 3 added.
  - Then shift the concatenation {working BCD, binary} left by 1.
  - Decrement the counter. The cycle that consumes the last bit goes to DONE.
- DONE:
  - Working BCD copies to BCD and the pending sign to Sign, on the same edge.
  - Done is high for exactly this one cycle.
  - Next state is IDLE, or SHIFT if Start is high.
- BCD, Sign and Hex hold their previous values throughout SHIFT; no partial results are ever visible.
- Start in SHIFT is ignored and not queued. Res is sampled only at the accept edge; later changes to Res have no effect.
- Reset mid-conversion: the next edge forces IDLE and all reset values, discarding the partial result.
- Arithmetic: digit correction is 4-bit and never overflows, because a digit is at most 9 after correction and shift. Maximum input 65535 gives BCD 0x65535.

## Timing
- The accept edge is T0.
- Busy is high from after T0 through the cycle before the DONE cycle.
- SHIFT occupies N cycles (edges T0+1 .. T0+N).
- Done and the updated BCD/Sign are visible after edge T0+N+1.
- Latency from Start to Done is N+1 = 17 cycles.
- Start held high continuously gives one conversion per N+1 cycles, because the DONE cycle re-accepts Start.
- Hex is registered. It updates one cycle after BCD/Sign, at edge T0+N+2.

## Configuration
- Macro: RES_TO_BCD_SEG7_EN.
- Defined:
  - Hex carries decoded active-low patterns for digits 0–9.
  - Leading-zero digits are blanked (all ones), except the units digit, which always shows.
  - The sign display shows '-' (segment g only, 7'b0111111) when Sign=1, and blank otherwise.
- Undefined:
  - The decoder is not synthesised and Hex is tied to all ones.
  - BCD/Sign/Done behaviour is identical.

## Test plan
- Reset released, Start=1, Res=17'h00000 -> Done at cycle 17, BCD=20'h00000, Sign=0. With the macro, only the units display lit, showing 7'b1000000.
- Res=17'h0FE01 (255×255) -> Done 17 cycles after Start, BCD=20'h65025, Sign=0; Busy high for exactly 16 cycles.
- Res={1'b1,16'd1234} -> BCD=20'h01234, Sign=1. With the macro, the sign display is 7'b0111111 and the ten-thousands digit is blank.
- Res=17'h1FFFF then Res=17'h10000 (negative zero), back-to-back with Start held -> BCD=20'h65535 with Sign=1, then BCD=20'h00000 with Sign=0; Done pulses 17 cycles apart.
- Start at T0, Res changed and Start pulsed again at T0+5 -> second Start ignored, result matches the T0 operand, exactly one Done.
- Reset asserted at T0+8 mid-conversion -> next edge Busy=0, BCD=0, Sign=0, and no Done. A new Start after Reset gives a correct result at the normal latency.

Source files
------------

// File: rtl/res_to_bcd_if.sv
// res_to_bcd_if: groups the converter's request and result signals.
//   start  conversion request
//   res    sign-magnitude operand, sign at bit N
//   busy   conversion in progress
//   done   one-cycle pulse when bcd/sign update
//   sign   registered sign of the last result
//   bcd    packed BCD digits, units in [3:0]
//   hex    active-low seven-segment patterns, digits then sign display
// master: the producer/consumer side; slave: the converter.
interface res_to_bcd_if #(
  parameter int N      = 16,
  parameter int DIGITS = 5
);
  logic                      start;
  logic [N:0]                res;
  logic                      busy;
  logic                      done;
  logic                      sign;
  logic [4*DIGITS-1:0]       bcd;
  logic [7*(DIGITS+1)-1:0]   hex;

  modport master (output start, res, input busy, done, sign, bcd, hex);
  modport slave  (input start, res, output busy, done, sign, bcd, hex);
endinterface

// File: rtl/res_to_bcd.sv
// res_to_bcd: sequential sign-magnitude binary to BCD converter
// (shift-add-3, one magnitude bit per clock).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  res_to_bcd_if.slave (start/res in; busy/done/sign/bcd/hex out)
// Optional feature: define RES_TO_BCD_SEG7_EN to build the seven-segment
// decoder with leading-zero blanking; otherwise hex is tied to all ones.

// Per-digit correction: add 3 to any digit >= 5 before the shift.
module res_to_bcd_dig (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module res_to_bcd #(
  parameter int N      = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  res_to_bcd_if.slave   bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic [N-1:0]           mag;
  logic [N-1:0]           bin;
  logic [DIGITS-1:0][3:0] work, corr, bcd_q;
  logic [CW-1:0]          cnt;
  logic                   sign_pend, sign_q, done_q;

  assign mag = bus.res[N-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    res_to_bcd_dig u_dig (.d(work[i]), .q(corr[i]));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = SHIFT;
      end
      // cnt==1 means this edge consumes the last magnitude bit
      SHIFT: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: begin
        accept    = bus.start;
        state_nxt = bus.start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin       <= '0;
      work      <= '0;
      cnt       <= '0;
      sign_pend <= 1'b0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        bin       <= mag;
        work      <= '0;
        // negative zero is reported as +0
        sign_pend <= bus.res[N] & (|mag);
        cnt       <= CW'(N);
      end else if (state == SHIFT) begin
        {work, bin} <= {corr, bin} << 1;
        cnt         <= cnt - CW'(1);
      end
      // results publish on the edge leaving DONE; a re-accept on that same
      // edge clears work only after its old value has been copied
      done_q <= (state == DONE);
      if (state == DONE) begin
        bcd_q  <= work;
        sign_q <= sign_pend;
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_q;
  assign bus.sign = sign_q;
  assign bus.bcd  = bcd_q;

`ifdef RES_TO_BCD_SEG7_EN
  logic [7*(DIGITS+1)-1:0] hex_q, hex_nxt;
  logic                    lead;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Walk from the most significant digit; digits stay blank until the first
  // non-zero one, and the units digit is always shown.
  always_comb begin
    hex_nxt = '1;
    lead    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[i] != 4'd0 || i == 0) lead = 1'b0;
      if (!lead) hex_nxt[7*i +: 7] = seg7(bcd_q[i]);
    end
    hex_nxt[7*DIGITS +: 7] = sign_q ? 7'b0111111 : 7'b1111111;
  end

  always_ff @(posedge clk) begin
    if (rst) hex_q <= '1;
    else     hex_q <= hex_nxt;
  end

  assign bus.hex = hex_q;
`else
  assign bus.hex = '1;
`endif

endmodule

// File: tb/tb_res_to_bcd.sv
module tb_res_to_bcd;
  localparam int N = 16;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  res_to_bcd_if #(.N(N), .DIGITS(D)) bus ();
  res_to_bcd #(.N(N), .DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [19:0] last_bcd;
  logic        last_sign;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by plain division.
  function automatic logic [19:0] m_bcd(input logic [16:0] r);
    int m = int'(r[15:0]);
    int p = 1;
    logic [19:0] b = '0;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return b;
  endfunction

  function automatic logic m_sign(input logic [16:0] r);
    return r[16] && (r[15:0] != 16'd0);
  endfunction

  function automatic logic [41:0] m_hex(input logic [16:0] r);
    logic [41:0] h = '1;
`ifdef RES_TO_BCD_SEG7_EN
    logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int m = int'(r[15:0]);
    int p = 1;
    for (int i = 0; i < D; i++) begin
      if (i == 0 || m >= p) h[7*i +: 7] = tab[(m / p) % 10];
      p = p * 10;
    end
    if (m_sign(r)) h[7*D +: 7] = 7'b0111111;
`endif
    return h;
  endfunction

  task automatic accept(input logic [16:0] r);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.res   = r;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.res   = 17'($urandom);   // must not affect the conversion in flight
  endtask

  // Full conversion with latency, busy length, hold-during-shift and hex checks.
  task automatic conv(input logic [16:0] r, input string tag);
    int done_at = -1;
    int busy_cnt = 0;
    logic [19:0] ob = 'x;
    logic        os = 1'bx;
    logic [41:0] oh = 'x;
    accept(r);
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (j == 8) chk({tag, "_hold"}, {bus.sign, bus.bcd}, {last_sign, last_bcd});
      if (bus.done && done_at < 0) begin
        done_at = j;
        ob = bus.bcd;
        os = bus.sign;
      end
      if (done_at >= 0 && j == done_at + 1) begin
        oh = bus.hex;
        break;
      end
    end
    chk({tag, "_lat"},  64'(done_at), 64'(N + 1));
    chk({tag, "_busy"}, 64'(busy_cnt), 64'(N));
    chk({tag, "_bcd"},  ob, m_bcd(r));
    chk({tag, "_sign"}, os, m_sign(r));
    chk({tag, "_hex"},  oh, m_hex(r));
    last_bcd  = m_bcd(r);
    last_sign = m_sign(r);
  endtask

  initial begin
    int nd, d0, d1;
    logic [19:0] b0, b1;
    logic s0, s1;
    logic [16:0] a;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.res = '0;
    last_bcd = '0;
    last_sign = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_sign", bus.sign, 1'b0);
    chk("rst_bcd",  bus.bcd, 20'h0);
    chk("rst_hex",  bus.hex, {42{1'b1}});
    @(posedge clk); #1 rst = 1'b0;

    conv(17'h00000, "zero");
    conv(17'h0FE01, "sq255");
    conv({1'b1, 16'd1234}, "neg1234");
    conv(17'h0FFFF, "max");
    conv(17'h00009, "nine");
    conv({1'b1, 16'd10}, "neg10");
    for (int k = 0; k < 8; k++) conv(17'($urandom), "rand");

    // back-to-back with start held; second operand is negative zero
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.res = 17'h1FFFF;
    @(posedge clk); #1;
    bus.res = 17'h10000;
    nd = 0; d0 = -1; d1 = -1;
    b0 = 'x; b1 = 'x; s0 = 1'bx; s1 = 1'bx;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.done) begin
        if (nd == 0) begin d0 = j; b0 = bus.bcd; s0 = bus.sign; end
        else if (nd == 1) begin d1 = j; b1 = bus.bcd; s1 = bus.sign; end
        nd++;
      end
      if (j == 17) bus.start = 1'b0;
    end
    chk("b2b_d0",   64'(d0), 64'(N + 1));
    chk("b2b_d1",   64'(d1), 64'(2 * (N + 1)));
    chk("b2b_bcd0", {s0, b0}, {1'b1, 20'h65535});
    chk("b2b_bcd1", {s1, b1}, {1'b0, 20'h00000});
    last_bcd = 20'h0;
    last_sign = 1'b0;

    // start during SHIFT is ignored; res change has no effect
    a = 17'($urandom);
    accept(a);
    nd = 0; b0 = 'x;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 4) begin bus.start = 1'b1; bus.res = ~a; end
      if (j == 5) bus.start = 1'b0;
      if (bus.done) begin
        nd++;
        if (j == N + 1) b0 = bus.bcd;
      end
    end
    chk("ign_ndone", 64'(nd), 64'd1);
    chk("ign_bcd",   b0, m_bcd(a));
    last_bcd = m_bcd(a);
    last_sign = m_sign(a);

    // reset mid-conversion after a non-zero result is on the outputs
    conv({1'b1, 16'd777}, "pre_rst");
    accept(17'd4321);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 7) rst = 1'b1;
    end
    @(negedge clk);
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_done", bus.done, 1'b0);
    chk("mrst_bcd",  bus.bcd, 20'h0);
    chk("mrst_sign", bus.sign, 1'b0);
    chk("mrst_hex",  bus.hex, {42{1'b1}});
    rst = 1'b0;
    nd = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("mrst_nodone", 64'(nd), 64'd0);
    last_bcd = '0;
    last_sign = 1'b0;
    conv(17'($urandom), "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
